// File: rtl/alu_bist_sched_if.sv
// rtl/alu_bist_sched_if.sv - control/status bundle between the ALU BIST scheduler and its host
interface alu_bist_sched_if;
  logic        start;
  logic        periodic_en;
  logic        abort;
  logic        fault_detected;
  logic        test_en;
  logic        test_done;
  logic [31:0] lfsr_out;
  logic        busy;
  logic        result_valid;
  logic        test_fail;
  logic        fail_sticky;
  logic [15:0] pass_cnt;
  logic        aborted;

  // Host / ALU side: issues requests and the MISR verdict, observes status
  modport master (
    output start, periodic_en, abort, fault_detected,
    input  test_en, test_done, lfsr_out, busy, result_valid,
    input  test_fail, fail_sticky, pass_cnt, aborted
  );

  // Scheduler side
  modport slave (
    input  start, periodic_en, abort, fault_detected,
    output test_en, test_done, lfsr_out, busy, result_valid,
    output test_fail, fail_sticky, pass_cnt, aborted
  );
endinterface

// File: rtl/alu_bist_sched.sv
// rtl/alu_bist_sched.sv - online BIST scheduler: pattern LFSR, run control and pass/fail history
module alu_bist_sched #(
  parameter int unsigned N_PATTERNS    = 256,
  parameter int unsigned TEST_INTERVAL = 4096,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
  parameter logic [31:0] LFSR_POLY     = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             rst,
  alu_bist_sched_if.slave  bus
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam int          IW       = $clog2(TEST_INTERVAL);
  localparam logic [IW-1:0] INT_LAST = IW'(TEST_INTERVAL - 1);
  localparam logic [15:0]   PAT_LAST = 16'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t        state;
  logic [31:0]   lfsr;
  logic [15:0]   pat_cnt;
  logic [IW-1:0] int_cnt;
  logic          test_en_q;
  logic          test_done_q;
  logic          busy_q;
  logic          result_valid_q;
  logic          test_fail_q;
  logic          fail_sticky_q;
  logic [15:0]   pass_cnt_q;
  logic          aborted_q;

  logic          trig;
  logic [31:0]   lfsr_next;

  // Launch request: software start or interval tick; abort in the same cycle suppresses it
  assign trig = (bus.start | (bus.periodic_en & (int_cnt == INT_LAST))) & ~bus.abort;

  // Galois LFSR step
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);

  // Scheduler FSM; every output is a register updated together with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      lfsr           <= SEED;
      pat_cnt        <= '0;
      int_cnt        <= '0;
      test_en_q      <= 1'b0;
      test_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      test_fail_q    <= 1'b0;
      fail_sticky_q  <= 1'b0;
      pass_cnt_q     <= '0;
      aborted_q      <= 1'b0;
    end else begin
      test_done_q    <= 1'b0;
      result_valid_q <= 1'b0;
      aborted_q      <= 1'b0;
      if (!bus.periodic_en) begin
        int_cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (trig) begin
            state   <= LOAD;
            busy_q  <= 1'b1;
            int_cnt <= '0;
          end else if (bus.periodic_en) begin
            int_cnt <= int_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            state     <= RUN;
            lfsr      <= SEED;
            pat_cnt   <= '0;
            test_en_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            test_en_q <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            lfsr    <= lfsr_next;
            pat_cnt <= pat_cnt + 16'd1;
            if (pat_cnt == PAT_LAST) begin
              state       <= DONE;
              test_en_q   <= 1'b0;
              test_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= CHECK;
        end
        CHECK: begin
          // MISR verdict is valid the cycle after test_done; result_valid accompanies the update
          state          <= IDLE;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b1;
          test_fail_q    <= bus.fault_detected;
          if (bus.fault_detected) begin
            fail_sticky_q <= 1'b1;
          end else if (pass_cnt_q != 16'hFFFF) begin
            pass_cnt_q <= pass_cnt_q + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          test_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.test_en      = test_en_q;
  assign bus.test_done    = test_done_q;
  assign bus.lfsr_out     = lfsr;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.test_fail    = test_fail_q;
  assign bus.fail_sticky  = fail_sticky_q;
  assign bus.pass_cnt     = pass_cnt_q;
  assign bus.aborted      = aborted_q;

endmodule

// File: tb/tb_alu_bist_sched.sv
// tb/tb_alu_bist_sched.sv - self-checking bench for alu_bist_sched
module tb_alu_bist_sched;

  localparam int          NP   = 4;
  localparam int          TI   = 8;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  int          exp_pass   = 0;
  bit          exp_sticky = 1'b0;
  bit          exp_fail   = 1'b0;

  alu_bist_sched_if bus ();

  alu_bist_sched #(
    .N_PATTERNS    (NP),
    .TEST_INTERVAL (TI),
    .LFSR_SEED     (SEED),
    .LFSR_POLY     (POLY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ ((x & 32'h1) != 0 ? POLY : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_status(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_test_en"}, bus.test_en, 1'b0);
    check({tag, "_pass_cnt"}, bus.pass_cnt, 32'(exp_pass));
    check({tag, "_fail_sticky"}, bus.fail_sticky, exp_sticky);
    check({tag, "_test_fail"}, bus.test_fail, exp_fail);
  endtask

  // Follows one full test starting in its LOAD cycle, ends in the first IDLE cycle
  task automatic follow_test(input bit fault, input bit poke_start, input bit abort_done);
    logic [31:0] p;
    p = SEED;
    check("load_busy", bus.busy, 1'b1);
    check("load_test_en", bus.test_en, 1'b0);
    for (int i = 0; i < NP; i++) begin
      tick();
      bus.start = (poke_start && i == 1) ? 1'b1 : 1'b0;
      check("run_test_en", bus.test_en, 1'b1);
      check("run_pattern", bus.lfsr_out, p);
      check("run_test_done", bus.test_done, 1'b0);
      p = lfsr_step(p);
    end
    tick();
    bus.start = 1'b0;
    bus.abort = abort_done;
    check("done_test_done", bus.test_done, 1'b1);
    check("done_test_en", bus.test_en, 1'b0);
    check("done_result_valid", bus.result_valid, 1'b0);
    tick();
    bus.abort = 1'b0;
    bus.fault_detected = fault;
    check("check_busy", bus.busy, 1'b1);
    check("check_test_done", bus.test_done, 1'b0);
    tick();
    bus.fault_detected = 1'b0;
    exp_fail = fault;
    if (fault) exp_sticky = 1'b1;
    else if (exp_pass < 65535) exp_pass++;
    check("result_valid", bus.result_valid, 1'b1);
    check("aborted_quiet", bus.aborted, 1'b0);
    check_idle_status("result");
  endtask

  task automatic run_test(input bit fault, input bit poke_start, input bit abort_done);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    follow_test(fault, poke_start, abort_done);
    tick();
    check("result_valid_pulse", bus.result_valid, 1'b0);
    check("no_requeue_busy", bus.busy, 1'b0);
  endtask

  // Abort after pos cycles past LOAD (0 = in LOAD, k = in k-th RUN cycle)
  task automatic abort_test(input int pos);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < pos; k++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_pulse", bus.aborted, 1'b1);
    check("abort_test_en", bus.test_en, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    for (int k = 0; k < NP + 4; k++) begin
      tick();
      check("abort_no_done", bus.test_done, 1'b0);
      check("abort_no_result", bus.result_valid, 1'b0);
      check("abort_pulse_end", bus.aborted, 1'b0);
    end
    check_idle_status("abort_hist");
  endtask

  task automatic wait_load(input int exp_gap, input string tag);
    int k;
    k = 0;
    while (bus.busy !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check(tag, k, exp_gap);
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.periodic_en    = 1'b0;
    bus.abort          = 1'b0;
    bus.fault_detected = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_lfsr", bus.lfsr_out, SEED);
    check("rst_test_done", bus.test_done, 1'b0);
    check("rst_result_valid", bus.result_valid, 1'b0);
    check("rst_aborted", bus.aborted, 1'b0);
    check_idle_status("rst");
    rst = 1'b1;
    tick();

    // Basic runs: pass, then fail
    run_test(1'b0, 1'b0, 1'b0);
    run_test(1'b1, 1'b0, 1'b0);

    // Randomized verdicts with random idle gaps
    for (int r = 0; r < 4; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_test(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Periodic launches: 8 idle cycles before each LOAD
    bus.periodic_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_load(TI, "periodic_gap");
      follow_test(1'b0, 1'b0, 1'b0);
    end
    bus.periodic_en = 1'b0;
    tick();

    // Abort in 2nd RUN cycle, replay from seed, then random abort points
    abort_test(2);
    run_test(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      abort_test(int'($urandom_range(0, NP)));
    end
    run_test(1'b0, 1'b0, 1'b0);

    // Abort in DONE is ignored
    run_test(1'b0, 1'b0, 1'b1);

    // Abort beats start in the same cycle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_over_start_busy", bus.busy, 1'b0);
    check("abort_over_start_pulse", bus.aborted, 1'b0);
    tick();

    // start coinciding with the periodic tick gives one test; start during RUN is dropped
    bus.periodic_en = 1'b1;
    for (int k = 0; k < TI - 1; k++) begin
      tick();
      check("coinc_wait_busy", bus.busy, 1'b0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    follow_test(1'b0, 1'b1, 1'b0);
    wait_load(TI, "coinc_next_gap");
    follow_test(1'b0, 1'b0, 1'b0);
    bus.periodic_en = 1'b0;
    tick();
    check("coinc_idle_busy", bus.busy, 1'b0);
    run_test(1'b0, 1'b1, 1'b0);

    // Saturation of the pass counter
    force dut.pass_cnt_q = 16'hFFFE;
    #1;
    release dut.pass_cnt_q;
    exp_pass = 65534;
    check("sat_preload", bus.pass_cnt, 16'hFFFE);
    for (int r = 0; r < 3; r++) run_test(1'b0, 1'b0, 1'b0);
    run_test(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_rst_test_en", bus.test_en, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    exp_pass = 0;
    exp_sticky = 1'b0;
    exp_fail = 1'b0;
    check("midrst_lfsr", bus.lfsr_out, SEED);
    check("midrst_result_valid", bus.result_valid, 1'b0);
    check_idle_status("midrst");
    tick();
    rst = 1'b1;
    for (int k = 0; k < NP + 4; k++) begin
      tick();
      check("post_rst_no_result", bus.result_valid, 1'b0);
    end
    run_test(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
